// File: rtl/cpu_clock_ctrl_pkg.sv
// ==== cpu_clock_ctrl_pkg : shared state type and parameter defaults ====
// Rev 1.0
`default_nettype none

package cpu_clock_ctrl_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int DIV_W_DEF           = 27;
  localparam int CNT_W_DEF           = 16;

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/input_debouncer.sv
// ==== input_debouncer : 2-flop synchronizer plus stable-count debouncer ====
// Rev 1.0
`default_nettype none

module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_clock_ctrl.sv
// ==== cpu_clock_ctrl : run/halt/single-step controller producing cpu_tick ====
// Rev 1.0
`default_nettype none

module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DIV_W           = DIV_W_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [DIV_W-1:0] period,
  output logic             cpu_tick,
  output logic             running,
  output logic [CNT_W-1:0] tick_count
);

  logic             run_lvl;
  logic             step_lvl;
  logic             step_prev;
  logic             step_pulse;
  state_e           state;
  state_e           state_next;
  logic [DIV_W-1:0] pc;
  logic [DIV_W-1:0] pc_next;
  logic [DIV_W-1:0] term;
  logic             tick_next;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (run_sw),
    .level (run_lvl)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (step_lvl)
  );

  assign step_pulse = step_lvl & ~step_prev;
  assign term       = (period == '0) ? '0 : period - DIV_W'(1);
  assign running    = (state == ST_RUN);

  always_comb begin
    state_next = state;
    pc_next    = '0;
    tick_next  = 1'b0;
    case (state)
      ST_HALT: begin
        tick_next = step_pulse;
        if (run_lvl && !halt_req) state_next = ST_RUN;
      end
      ST_RUN: begin
        // >= so a period shrunk below the running count ticks at once instead of wrapping.
        if (!run_lvl || halt_req) begin
          state_next = ST_HALT;
        end else if (pc >= term) begin
          tick_next = 1'b1;
        end else begin
          pc_next = pc + DIV_W'(1);
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_HALT;
      pc         <= '0;
      cpu_tick   <= 1'b0;
      step_prev  <= 1'b0;
      tick_count <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      cpu_tick  <= tick_next;
      step_prev <= step_lvl;
      if (cpu_tick) tick_count <= tick_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
// ==== tb_cpu_clock_ctrl : randomized scoreboard bench for cpu_clock_ctrl ====
// Rev 1.0
`default_nettype none

module tb_cpu_clock_ctrl;

  localparam int D     = 4;
  localparam int DIV_W = 27;
  localparam int CNT_W = 16;
  localparam int HL    = D + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             run_sw = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt_req = 1'b0;
  logic [DIV_W-1:0] period = '0;
  logic             cpu_tick;
  logic             running;
  logic [CNT_W-1:0] tick_count;

  cpu_clock_ctrl #(.DEBOUNCE_CYCLES(D), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .halt_req   (halt_req),
    .period     (period),
    .cpu_tick   (cpu_tick),
    .running    (running),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int n        = 0;
  int exp_q[$];

  // Reference model: raw input histories, accepted levels, mode and tick bookkeeping.
  logic             run_h [HL];
  logic             step_h[HL];
  logic             m_run_lvl, m_step_lvl, m_step_old, m_run_mode;
  int               m_last;
  logic [CNT_W-1:0] m_total, exp_count;
  logic             exp_running;

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
  endtask

  task automatic model_clear();
    for (int k = 0; k < HL; k++) begin
      run_h[k]  = 1'b0;
      step_h[k] = 1'b0;
    end
    m_run_lvl = 1'b0; m_step_lvl = 1'b0; m_step_old = 1'b0; m_run_mode = 1'b0;
    m_last = 0; m_total = '0; exp_count = '0; exp_running = 1'b0;
  endtask

  // A level is accepted once the last D samples reaching the debouncer all disagree with it.
  function automatic logic flips(input logic h[HL], input logic lvl);
    for (int j = 0; j < D; j++)
      if (h[2 + j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic tick, sp;
    int   p;
    n++;
    tick = 1'b0;
    sp   = m_step_lvl & ~m_step_old;
    p    = (period == '0) ? 1 : int'(period);
    if (!m_run_mode) begin
      tick = sp;
      if (m_run_lvl && !halt_req) begin
        m_run_mode = 1'b1;
        m_last     = n;
      end
    end else if (!m_run_lvl || halt_req) begin
      m_run_mode = 1'b0;
    end else if (n - m_last >= p) begin
      tick   = 1'b1;
      m_last = n;
    end
    if (tick) exp_q.push_back(n);
    exp_count   = m_total;
    if (tick) m_total = m_total + 1'b1;
    exp_running = m_run_mode;
    m_step_old  = m_step_lvl;
    for (int k = HL - 1; k > 0; k--) begin
      run_h[k]  = run_h[k-1];
      step_h[k] = step_h[k-1];
    end
    run_h[0]  = run_sw;
    step_h[0] = step_btn;
    if (flips(run_h, m_run_lvl))   m_run_lvl  = ~m_run_lvl;
    if (flips(step_h, m_step_lvl)) m_step_lvl = ~m_step_lvl;
  endtask

  task automatic cycle(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int k);
    reset = 1'b0;
    model_clear();
    repeat (k) begin
      @(posedge clk);
      n++;
      model_clear();
      @(negedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  // Monitor: every cycle compare levels, and pop the expected tick queue on each cpu_tick.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0] < n) begin
        chk_cnt++;
        $display("FAIL tick_missing: no cpu_tick at cycle %0d (now %0d)", exp_q[0], n);
        void'(exp_q.pop_front());
      end
      if (cpu_tick === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() > 0 && exp_q[0] == n) begin
          pass_cnt++;
          void'(exp_q.pop_front());
        end else begin
          $display("FAIL tick_unexpected: cpu_tick at cycle %0d, next expected %0d",
                   n, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
      end
      chk("running", running, exp_running);
      chk("tick_count", tick_count, exp_count);
    end
  end

  initial begin
    int hold;
    model_clear();
    do_reset(3);

    // Idle: nothing may move.
    cycle(50);
    chk("idle_tick_count", tick_count, 0);

    // One clean press: a single tick D+3 cycles after the edge.
    step_btn = 1'b1; cycle(20);
    step_btn = 1'b0; cycle(20);
    chk("step_tick_count", tick_count, 1);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 15; i++) begin
      step_btn = ~step_btn;
      cycle(2);
    end
    step_btn = 1'b0; cycle(10);
    chk("bounce_tick_count", tick_count, 1);

    // Run mode, period 5: running after D+3, then ten ticks five cycles apart.
    period = 27'd5; run_sw = 1'b1;
    cycle(58);
    chk("run10_tick_count", tick_count, 11);

    // Period 0 ticks every cycle; halt pulse suppresses and drops running.
    period = '0; cycle(10);
    halt_req = 1'b1; cycle(1);
    halt_req = 1'b0; cycle(8);
    run_sw = 1'b0; halt_req = 1'b1; cycle(12);
    step_btn = 1'b1; cycle(10);
    step_btn = 1'b0; cycle(10);
    halt_req = 1'b0; cycle(4);

    // Randomized mix of switch, button, halt, period changes and occasional resets.
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 3) != 0) run_sw = $urandom_range(0, 1);
      step_btn = $urandom_range(0, 1);
      halt_req = ($urandom_range(0, 7) == 0);
      period   = DIV_W'($urandom_range(0, 7));
      hold     = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
      else cycle(hold);
    end

    // Reset mid-RUN with period 3, then re-entry through the debounce path.
    run_sw = 1'b1; step_btn = 1'b0; halt_req = 1'b0; period = 27'd3;
    cycle(20);
    chk("pre_reset_running", running, 1);
    do_reset(1);
    chk("reset_tick_count", tick_count, 0);
    chk("reset_running", running, 0);
    chk("reset_tick", cpu_tick, 0);
    cycle(D + 2);
    chk("rerun_not_yet", running, 0);
    cycle(20);

    run_sw = 1'b0;
    cycle(10);
    chk("pending_ticks", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
